// File: rtl/alu_div_seq.sv
// Multicycle signed divider: restoring shift-subtract, one quotient bit per cycle.
// Magnitudes are divided and the signs are reapplied in the final FIX cycle.
module alu_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MinInt  = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] NegOne  = {WIDTH{1'b1}};
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  // Stored remainder is always below the divisor, so WIDTH bits suffice between
  // steps; the WIDTH+1-bit working value only exists inside one step.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_signed, rem_signed;

  // Operand magnitudes, one iteration step, and sign-corrected final values.
  always_comb begin
    abs_a      = data_operandA[WIDTH-1] ? (~data_operandA + One) : data_operandA;
    abs_b      = data_operandB[WIDTH-1] ? (~data_operandB + One) : data_operandB;
    rem_sh     = {rem_q, quo_q[WIDTH-1]};
    // Subtract as add of inverted divisor with carry-in 1.
    diff       = rem_sh + ~{1'b0, div_q} + {{WIDTH{1'b0}}, 1'b1};
    quo_signed = sign_q_q ? (~quo_q + One) : quo_q;
    rem_signed = sign_r_q ? (~rem_q + One) : rem_q;
  end

  // Next-state and datapath update; a start pulse overrides any state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    div_d       = div_q;
    rem_d       = rem_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    rdy_d       = 1'b0;

    unique case (state_q)
      StIter: begin
        rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (zero_q) begin
          // Division by zero leaves |A| in rem, so the signed remainder is A.
          result_d    = '0;
          remainder_d = rem_signed;
        end else if (ovf_q) begin
          result_d    = MinInt;
          remainder_d = '0;
        end else begin
          result_d    = quo_signed;
          remainder_d = rem_signed;
        end
        exc_d   = zero_q | ovf_q;
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      StIdle: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Restart discards any operation in flight; a FIX-cycle RDY still goes out.
    if (ctrl_DIV) begin
      quo_d    = abs_a;
      div_d    = abs_b;
      rem_d    = '0;
      cnt_d    = '0;
      sign_q_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      sign_r_d = data_operandA[WIDTH-1];
      zero_d   = (data_operandB == '0);
      ovf_d    = (data_operandA == MinInt) && (data_operandB == NegOne);
      state_d  = StIter;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remainder_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: vector table, corner sequences, random run.
module tb_alu_div_seq;

  localparam int W = 32;
  localparam logic [31:0] MinInt = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  alu_div_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          start;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Advance to the next falling edge and score any completion seen there.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    if (reset_n && data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy at cycle %0d: got rdy=1 expected rdy=0", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("remainder", data_remainder, e.rem);
        chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
        chk("latency", 32'(cyc - e.start), 32'd33);
      end
    end
  endtask

  // Drive a one-cycle start pulse; the sampling edge is the next rising edge.
  task automatic start_op(input logic [31:0] ra, input logic [31:0] rb,
                          input logic [31:0] er, input logic [31:0] erem, input logic ex);
    op_a     = ra;
    op_b     = rb;
    ctrl_DIV = 1'b1;
    sb.push_back('{res: er, rem: erem, exc: ex, start: cyc + 1});
    tick();
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout at cycle %0d: got %0d pending expected 0", cyc, sb.size());
      sb.delete();
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.start = 0;
    if (y == 32'd0) begin
      e.res = 32'd0; e.rem = x; e.exc = 1'b1;
    end else if (x == MinInt && y == 32'hFFFF_FFFF) begin
      e.res = MinInt; e.rem = 32'd0; e.exc = 1'b1;
    end else begin
      e.res = $signed(x) / $signed(y);
      e.rem = $signed(x) % $signed(y);
      e.exc = 1'b0;
    end
    return e;
  endfunction

  vec_t vecs[12];

  initial begin
    exp_t        m;
    logic [31:0] ra, rb;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0};
    vecs[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
    vecs[4]  = '{32'd5,         32'd0,         32'd0,         32'd5,         1'b1};
    vecs[5]  = '{32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b1};
    vecs[7]  = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0};
    vecs[8]  = '{32'hFFFF_FFFB, 32'd0,         32'd0,         32'hFFFF_FFFB, 1'b1};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0,         1'b0};
    vecs[11] = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 32'd0);
    chk("rst_remainder", data_remainder, 32'd0);
    chk("rst_exception", {31'b0, data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Table of fixed vectors, one at a time
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].rem, vecs[i].exc);
      wait_done();
      tick();
    end

    // Busy window and single-cycle RDY
    start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    chk("busy_e0", {31'b0, busy}, 32'd1);
    repeat (32) tick();
    chk("busy_e32", {31'b0, busy}, 32'd1);
    chk("rdy_e32", {31'b0, data_resultRDY}, 32'd0);
    tick();
    chk("busy_e33", {31'b0, busy}, 32'd0);
    chk("rdy_e33", {31'b0, data_resultRDY}, 32'd1);
    tick();
    chk("rdy_e34", {31'b0, data_resultRDY}, 32'd0);
    chk("hold_result", data_result, 32'd14);

    // Restart mid-operation: the aborted 1000/10 must never complete
    start_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    repeat (9) tick();
    sb.delete();
    start_op(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);
    wait_done();
    repeat (5) tick();

    // Asynchronous reset mid-operation
    start_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    repeat (19) tick();
    @(posedge clock);
    #1 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_result", data_result, 32'd0);
    chk("mid_rst_remainder", data_remainder, 32'd0);
    chk("mid_rst_exception", {31'b0, data_exception}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) tick();
    start_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    wait_done();
    tick();

    // Random run, each start landing on the previous operation's FIX edge
    for (int i = 0; i < 1000; i++) begin
      do begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 1) == 0) begin
          rb = 32'($urandom_range(1, 1000));
          if ($urandom_range(0, 1) == 0) rb = ~rb + 32'd1;
        end
        if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
      end while (rb == 32'd0 || (ra == MinInt && rb == 32'hFFFF_FFFF));
      m = model(ra, rb);
      start_op(ra, rb, m.res, m.rem, m.exc);
      if (i != 999) repeat (32) tick();
    end
    wait_done();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
